instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder: the inverse of the core's control decode path. It accepts symbolic operation requests (instruction class, ALU_op code from `cpu_defs`, register indices, immediate) over a valid/ready handshake. It packs each request into a 32-bit RV32I word, tags it with an auto-incrementing instruction-memory address, and queues it in a small FIFO for the program-loader/instruction-memory write port. It is used by the boot loader and by the self-test sequencer to generate programs in hardware.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; a power of two, at least 2.
- `ADDR_W`, default 16: width of the instruction byte address.
- `RESET_ADDR`, default 0: value of the next-address counter after reset.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  encoder can accept a request.
- `req_class`  in  3  0=R, 1=I, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=NOP.
- `req_alu_op`  in  4  `cpu_defs` ALU_op code.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices.
- `req_imm`  in  32  signed immediate; branch/jump offsets are in bytes.
- `addr_load`  in  1  load the next-address counter.
- `addr_in`  in  ADDR_W  value for `addr_load`.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer takes the head.
- `out_instr`  out  32  encoded word at the FIFO head.
- `out_addr`  out  ADDR_W  byte address of `out_instr`.
- `err`  out  1  one-cycle pulse when a request is rejected.
- `err_count`  out  8  saturating count of rejected requests.

## Operation
- Accept occurs when `req_valid & req_ready`. `req_ready` is 1 exactly when the FIFO is not full. It has no combinational path from `out_ready`, and it is 0 while `rst` is high.
- Encoding of legal requests:
  - R (opcode 0110011): ADD 000/0000000, SUB 000/0100000, XOR 100, OR 110, AND 111, SLL 001, SRL 101/0000000, SRA 101/0100000.
  - I (0010011): same funct3 as R, with ADD meaning addi. Shifts put `imm[4:0]` in the shamt field and funct7 in [31:25]. SUB is illegal.
  - LOAD: lw (0000011, funct3 010). STORE: sw (0100011, funct3 010, split imm). The ALU_op value is ignored.
  - BRANCH (1100011): BEQ 000, BNE 001, BLT 100, BGE 101, B-format imm.
  - JAL (1101111): J-format imm into rd. JALR (1100111): funct3 000.
  - NOP: 0x00000013. All other fields are ignored.
- Legal accepted word: pushed together with address `next_addr`, then `next_addr += 4`, modulo 2^ADDR_W (wraps silently).
- Illegal accepted request: not pushed, and the address does not advance. `err` pulses the next cycle and `err_count` increments, saturating at 255. A request is illegal if:
  - its ALU_op is not in the class's list above, or
  - it fails a range check (see Configuration).
- `addr_load`: `next_addr <= addr_in`. Entries already queued keep their addresses. If `addr_load` coincides with a legal push, the pushed word takes `addr_in` and `next_addr <= addr_in + 4`.
- Pop occurs when `out_valid & out_ready`. Simultaneous push and pop leaves the count unchanged; a push is never lost.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=0, `err`=0, `err_count`=0, FIFO empty, `next_addr`=`RESET_ADDR`. `req_ready`=1 in the first cycle after `rst` falls.
- Latency: a request accepted at edge N appears at `out_*` after edge N when the FIFO was empty. Otherwise it appears in FIFO order.
- Throughput: one request per cycle while not full. When full, a pop at edge N raises `req_ready` after edge N.
- `out_instr` and `out_addr` are held stable while `out_valid & !out_ready`.
- `rst` asserted mid-stream flushes the FIFO and all queued words are discarded. `err_count` is cleared.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: a request is rejected as illegal if its immediate does not fit its field:
  - I/LOAD/STORE/JALR: signed 12-bit.
  - Shifts: 0..31.
  - BRANCH: signed 13-bit and even.
  - JAL: signed 21-bit and even.
- Not defined: no range checks. The immediate is truncated to the field and the low bit is dropped for BRANCH/JAL. Only illegal ALU_op/class combinations raise `err`.

## Test plan
- After reset, push R/ADD rd=1 rs1=2 rs2=3, then R/SUB with the same registers -> `out_instr` 0x003100B3 at `out_addr` 0, then 0x403100B3 at `out_addr` 4.
- I/SRA rd=5 rs1=6 imm=3 -> 0x40335293. NOP -> 0x00000013. BRANCH/BNE rs1=1 rs2=2 imm=-4 -> 0xFE209EE3. JAL rd=1 imm=8 -> 0x008000EF.
- Hold `out_ready`=0 and push `DEPTH`+1 requests -> `req_ready` falls after `DEPTH` accepts. Then assert `out_ready` with `req_valid` held high -> one pop and one push per cycle, with no loss and no reordering.
- Request I/SUB -> `err` pulses once, `err_count`=1, nothing is pushed, and the next legal word still gets the unadvanced address. Send 300 illegal requests -> `err_count`=255.
- `addr_load` with `addr_in`=0xFFFC coinciding with two legal pushes (ADDR_W=16) -> addresses are 0xFFFC then 0x0000.
- With `ENC_RANGE_CHECK_EN`, I/ADD imm=2048 -> `err` pulse. Without it -> 0x80000013 for rd=0 rs1=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: symbolic request side, encoded-word FIFO side,
// and reject status. The master drives requests; the slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_class;
  logic [3:0]        req_alu_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [7:0]        err_count;

  modport master (
    output req_valid, req_class, req_alu_op, req_rd, req_rs1, req_rs2, req_imm,
           addr_load, addr_in, out_ready,
    input  req_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport slave (
    input  req_valid, req_class, req_alu_op, req_rd, req_rs1, req_rs2, req_imm,
           addr_load, addr_in, out_ready,
    output req_ready, out_valid, out_instr, out_addr, err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic requests into RV32I words, tags them with an auto-incrementing byte address
// and queues them in a DEPTH-entry FIFO. Optional immediate range checks: ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RESET_ADDR = 0
) (
  input logic             clk,
  input logic             rst,
  instr_encoder_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // cpu_defs ALU_op codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_BEQ = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;
  localparam logic [3:0] ALU_BLT = 4'd10;
  localparam logic [3:0] ALU_BGE = 4'd11;

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_I      = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;
  localparam logic [2:0] CLS_JALR   = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [31:0] imm;
  logic [3:0]  op;
  logic [4:0]  rd, rs1, rs2;
  assign imm = bus.req_imm;
  assign op  = bus.req_alu_op;
  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        r_op, br_op, is_shift;
  logic        fit12, fit13, fit21, shamt_ok;
  logic        op_ok, fit, legal;
  logic [31:0] enc_word;

  always_comb begin
    f3 = 3'b000;
    case (op)
      ALU_SLL, ALU_BNE:          f3 = 3'b001;
      ALU_XOR, ALU_BLT:          f3 = 3'b100;
      ALU_SRL, ALU_SRA, ALU_BGE: f3 = 3'b101;
      ALU_OR:                    f3 = 3'b110;
      ALU_AND:                   f3 = 3'b111;
      default:                   f3 = 3'b000;
    endcase
  end

  assign f7       = (op == ALU_SUB || op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
  assign r_op     = (op <= ALU_SRA);
  assign br_op    = (op >= ALU_BEQ) && (op <= ALU_BGE);
  assign is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);

  // Signed fit: every bit above the field's sign bit must equal the sign bit.
  assign fit12    = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13    = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fit21    = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign shamt_ok = ~(|imm[31:5]);

  always_comb begin
    enc_word = '0;
    op_ok    = 1'b0;
    fit      = 1'b1;
    case (bus.req_class)
      CLS_R: begin
        op_ok    = r_op;
        enc_word = {f7, rs2, rs1, f3, rd, OPC_OP};
      end
      CLS_I: begin
        op_ok = r_op && (op != ALU_SUB);
        if (is_shift) begin
          fit      = shamt_ok;
          enc_word = {f7, imm[4:0], rs1, f3, rd, OPC_OPIMM};
        end else begin
          fit      = fit12;
          enc_word = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
        end
      end
      CLS_LOAD: begin
        op_ok    = 1'b1;
        fit      = fit12;
        enc_word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      end
      CLS_STORE: begin
        op_ok    = 1'b1;
        fit      = fit12;
        enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        op_ok    = br_op;
        fit      = fit13;
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        op_ok    = 1'b1;
        fit      = fit21;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      CLS_JALR: begin
        op_ok    = 1'b1;
        fit      = fit12;
        enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      default: begin
        op_ok    = 1'b1;
        enc_word = 32'h0000_0013;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  assign legal = op_ok & fit;
`else
  logic unused_fit;
  assign legal      = op_ok;
  assign unused_fit = fit;
`endif

  logic [31:0]       mem_q   [DEPTH];
  logic [31:0]       mem_d   [DEPTH];
  logic [ADDR_W-1:0] maddr_q [DEPTH];
  logic [ADDR_W-1:0] maddr_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, base_addr;
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              full, empty, ready, accept, push, reject, pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign ready     = !full && !rst;
  assign accept    = bus.req_valid && ready;
  assign push      = accept && legal;
  assign reject    = accept && !legal;
  assign pop       = !empty && bus.out_ready;
  assign base_addr = bus.addr_load ? bus.addr_in : next_addr_q;

  always_comb begin
    mem_d       = mem_q;
    maddr_d     = maddr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    next_addr_d = base_addr;
    err_d       = reject;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q]   = enc_word;
      maddr_d[wr_ptr_q] = base_addr;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      next_addr_d       = base_addr + ADDR_W'(4);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    if (reject && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      next_addr_q <= ADDR_W'(RESET_ADDR);
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    maddr_q <= maddr_d;
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_addr  = empty ? '0 : maddr_q[rd_ptr_q];
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic against a
// queue-based reference model. Honours ENC_RANGE_CHECK_EN the same way the design does.
module tb_instr_encoder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 16;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_XOR = 2, OP_OR = 3, OP_AND = 4;
  localparam int OP_SLL = 5, OP_SRL = 6, OP_SRA = 7;
  localparam int OP_BEQ = 8, OP_BNE = 9, OP_BLT = 10, OP_BGE = 11;
  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_NOP = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW)) bus ();
  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .RESET_ADDR(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_next = '0;
  int            m_errc = 0;
  bit            m_err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int funct3_of(input int op);
    case (op)
      OP_SLL, OP_BNE:         return 1;
      OP_XOR, OP_BLT:         return 4;
      OP_SRL, OP_SRA, OP_BGE: return 5;
      OP_OR:                  return 6;
      OP_AND:                 return 7;
      default:                return 0;
    endcase
  endfunction

  // Returns {legal, word}
  function automatic logic [32:0] model_encode(input int cls, input int op, input int rd,
                                               input int rs1, input int rs2, input logic [31:0] imm);
    int s, f3, f7, w;
    bit op_ok, fits;
    s = int'(imm);
    f3 = funct3_of(op);
    f7 = (op == OP_SUB || op == OP_SRA) ? 32 : 0;
    op_ok = 1'b1;
    fits = 1'b1;
    w = 0;
    case (cls)
      C_R: begin
        op_ok = (op >= 0 && op <= 7);
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      end
      C_I: begin
        op_ok = (op >= 0 && op <= 7 && op != OP_SUB);
        if (op == OP_SLL || op == OP_SRL || op == OP_SRA) begin
          fits = (s >= 0 && s <= 31);
          w = (f7 << 25) | ((s & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end else begin
          fits = (s >= -2048 && s <= 2047);
          w = ((s & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end
      end
      C_LOAD: begin
        fits = (s >= -2048 && s <= 2047);
        w = ((s & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      end
      C_STORE: begin
        fits = (s >= -2048 && s <= 2047);
        w = (((s >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((s & 31) << 7) | 'h23;
      end
      C_BR: begin
        op_ok = (op >= OP_BEQ && op <= OP_BGE);
        fits = (s >= -4096 && s <= 4095 && (s & 1) == 0);
        w = (((s >> 12) & 1) << 31) | (((s >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((s >> 1) & 15) << 8) | (((s >> 11) & 1) << 7) | 'h63;
      end
      C_JAL: begin
        fits = (s >= -1048576 && s <= 1048575 && (s & 1) == 0);
        w = (((s >> 20) & 1) << 31) | (((s >> 1) & 1023) << 21) | (((s >> 11) & 1) << 20) |
            (((s >> 12) & 255) << 12) | (rd << 7) | 'h6F;
      end
      C_JALR: begin
        fits = (s >= -2048 && s <= 2047);
        w = ((s & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
      end
      default: w = 'h13;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    return {op_ok && fits, 32'(w)};
`else
    return {op_ok, 32'(w)};
`endif
  endfunction

  task automatic model_step();
    bit acc, pop;
    logic [32:0] e;
    logic [AW-1:0] base;
    if (rst) begin
      mq.delete();
      m_next = '0;
      m_errc = 0;
      m_err = 1'b0;
      return;
    end
    acc = bus.req_valid && (mq.size() < DEPTH);
    pop = (mq.size() > 0) && bus.out_ready;
    base = bus.addr_load ? bus.addr_in : m_next;
    m_next = base;
    m_err = 1'b0;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      e = model_encode(int'(bus.req_class), int'(bus.req_alu_op), int'(bus.req_rd),
                       int'(bus.req_rs1), int'(bus.req_rs2), bus.req_imm);
      if (e[32]) begin
        mq.push_back('{instr: e[31:0], addr: base});
        m_next = base + AW'(4);
      end else begin
        m_err = 1'b1;
        if (m_errc < 255) m_errc++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(!rst && (mq.size() < DEPTH)));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_instr", bus.out_instr, mq[0].instr);
        chk("out_addr", 32'(bus.out_addr), 32'(mq[0].addr));
      end
      chk("err", 32'(bus.err), 32'(m_err));
      chk("err_count", 32'(bus.err_count), 32'(m_errc));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int cls, input int op, input int rd, input int rs1,
                           input int rs2, input logic [31:0] imm);
    bus.req_valid  = 1'b1;
    bus.req_class  = 3'(cls);
    bus.req_alu_op = 4'(op);
    bus.req_rd     = 5'(rd);
    bus.req_rs1    = 5'(rs1);
    bus.req_rs2    = 5'(rs2);
    bus.req_imm    = imm;
  endtask

  initial begin
    logic [32:0] e;
    int sel;
    bus.req_valid = 1'b0;
    bus.req_class = '0;
    bus.req_alu_op = '0;
    bus.req_rd = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_imm = '0;
    bus.addr_load = 1'b0;
    bus.addr_in = '0;
    bus.out_ready = 1'b0;

    // Pin the model against hand-computed encodings.
    e = model_encode(C_R, OP_ADD, 1, 2, 3, 32'd0);      chk("pin_add", e[31:0], 32'h003100B3);
    e = model_encode(C_R, OP_SUB, 1, 2, 3, 32'd0);      chk("pin_sub", e[31:0], 32'h403100B3);
    e = model_encode(C_I, OP_SRA, 5, 6, 0, 32'd3);      chk("pin_srai", e[31:0], 32'h40335293);
    e = model_encode(C_NOP, 0, 9, 9, 9, 32'd77);        chk("pin_nop", e[31:0], 32'h00000013);
    e = model_encode(C_BR, OP_BNE, 0, 1, 2, -32'sd4);   chk("pin_bne", e[31:0], 32'hFE209EE3);
    e = model_encode(C_JAL, 0, 1, 0, 0, 32'd8);         chk("pin_jal", e[31:0], 32'h008000EF);
    e = model_encode(C_STORE, 0, 0, 6, 5, -32'sd8);     chk("pin_sw", e[31:0], 32'hFE532C23);
    e = model_encode(C_I, OP_SUB, 1, 1, 1, 32'd0);      chk("pin_isub_illegal", 32'(e[32]), 32'd0);

    // Reset
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'h0);
    chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // ADD then SUB
    drive_req(C_R, OP_ADD, 1, 2, 3, 32'd0);
    tick();
    chk("add_word", bus.out_instr, 32'h003100B3);
    chk("add_addr", 32'(bus.out_addr), 32'h0);
    drive_req(C_R, OP_SUB, 1, 2, 3, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("sub_word", bus.out_instr, 32'h403100B3);
    chk("sub_addr", 32'(bus.out_addr), 32'h4);
    tick();
    bus.out_ready = 1'b0;

    // Illegal I/SUB does not advance the address
    drive_req(C_I, OP_SUB, 1, 1, 1, 32'd5);
    tick();
    bus.req_valid = 1'b0;
    chk("isub_err", 32'(bus.err), 32'd1);
    chk("isub_errcnt", 32'(bus.err_count), 32'd1);
    chk("isub_nopush", 32'(bus.out_valid), 32'd0);
    tick();
    chk("err_one_cycle", 32'(bus.err), 32'd0);
    drive_req(C_NOP, 0, 0, 0, 0, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("nop_word", bus.out_instr, 32'h00000013);
    chk("nop_addr", 32'(bus.out_addr), 32'h8);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Fill past DEPTH, then stream with pop and push each cycle
    for (int i = 0; i <= int'(DEPTH); i++) begin
      drive_req(C_I, OP_ADD, i + 1, 0, 0, 32'(i));
      tick();
      if (i == int'(DEPTH) - 1) chk("ready_full", 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("ready_after_pop", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive_req(C_I, OP_XOR, i, i + 1, 0, 32'(100 + i));
      tick();
    end
    bus.req_valid = 1'b0;
    repeat (DEPTH + 2) tick();
    bus.out_ready = 1'b0;

    // Address load coinciding with pushes, wrapping at 2^16
    bus.addr_load = 1'b1;
    bus.addr_in = 16'hFFFC;
    drive_req(C_NOP, 0, 0, 0, 0, 32'd0);
    tick();
    bus.addr_load = 1'b0;
    drive_req(C_R, OP_AND, 3, 4, 5, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("load_addr0", 32'(bus.out_addr), 32'h0000FFFC);
    bus.out_ready = 1'b1;
    tick();
    chk("load_addr_wrap", 32'(bus.out_addr), 32'h00000000);
    tick();
    bus.out_ready = 1'b0;

    // Saturating error count
    drive_req(C_R, 12, 1, 1, 1, 32'd0);
    repeat (300) tick();
    bus.req_valid = 1'b0;
    tick();
    chk("errcnt_sat", 32'(bus.err_count), 32'd255);

    // Out-of-range addi
    drive_req(C_I, OP_ADD, 0, 0, 0, 32'd2048);
    tick();
    bus.req_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    chk("addi_range_err", 32'(bus.err), 32'd1);
`else
    chk("addi_trunc", bus.out_instr, 32'h80000013);
`endif
    bus.out_ready = 1'b1;
    tick();

    // Randomized traffic with a mid-stream reset
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 1500 || c == 1501);
      bus.req_valid  = ($urandom_range(0, 9) < 7);
      bus.req_class  = 3'($urandom_range(0, 7));
      bus.req_alu_op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
      bus.req_rd     = 5'($urandom_range(0, 31));
      bus.req_rs1    = 5'($urandom_range(0, 31));
      bus.req_rs2    = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 3);
      case (sel)
        0: bus.req_imm = 32'($urandom_range(0, 63)) - 32'd32;
        1: bus.req_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        2: bus.req_imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        default: bus.req_imm = $urandom;
      endcase
      bus.addr_load = ($urandom_range(0, 31) == 0);
      bus.addr_in   = AW'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.addr_load = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
